// File: rtl/spin_index_dispatcher.sv
// spin_index_dispatcher: filters a batch of candidate spin indices (range check
// plus in-batch de-duplication), queues the survivors in lane order and issues
// them one per cycle over valid/ready. Keeps saturating batch/drop counters.
module spin_index_dispatcher #(
    parameter int SAMPLE        = 4,
    parameter int ADDR_BITWIDTH = 10,
    parameter int NUM_SPINS     = 1000,
    parameter int FIFO_DEPTH    = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ADDR_BITWIDTH-1:0]      in_index [SAMPLE],
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_BITWIDTH-1:0]      out_index,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [CNT_WIDTH-1:0]          drop_count,
    output logic [CNT_WIDTH-1:0]          batch_count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int KW = $clog2(SAMPLE + 1);

    localparam logic [LW-1:0]            DEPTH_L  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]            SAMPLE_L = LW'(SAMPLE);
    localparam logic [KW-1:0]            SAMPLE_K = KW'(SAMPLE);
    localparam logic [ADDR_BITWIDTH:0]   SPINS_L  = (ADDR_BITWIDTH + 1)'(NUM_SPINS);

    logic [ADDR_BITWIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [LW-1:0]            level_q;
    logic [CNT_WIDTH-1:0]     drop_q;
    logic [CNT_WIDTH-1:0]     batch_q;

    logic [SAMPLE-1:0]        in_rng;
    logic [SAMPLE-1:0]        keep;
    logic [PW-1:0]            slot_off [SAMPLE];
    logic [KW-1:0]            kept_cnt;
    logic                     accept;
    logic                     pop;
    logic [KW-1:0]            push_cnt;
    logic [LW-1:0]            level_next;
    logic [KW-1:0]            drop_inc;
    logic [CNT_WIDTH:0]       drop_sum;
    logic [CNT_WIDTH-1:0]     drop_next;
    logic [CNT_WIDTH-1:0]     batch_next;

    // Range check, first-occurrence de-duplication and compaction offsets per lane.
    always_comb begin
        int unsigned run;
        in_rng   = '0;
        keep     = '0;
        run      = 0;
        for (int unsigned i = 0; i < SAMPLE; i++) begin
            slot_off[i] = '0;
        end
        for (int unsigned i = 0; i < SAMPLE; i++) begin
            in_rng[i] = ({1'b0, in_index[i]} < SPINS_L);
        end
        for (int unsigned i = 0; i < SAMPLE; i++) begin
            keep[i] = in_rng[i];
            for (int unsigned j = 0; j < i; j++) begin
                if (in_rng[j] && (in_index[j] == in_index[i])) begin
                    keep[i] = 1'b0;
                end
            end
            slot_off[i] = PW'(run);
            if (keep[i]) begin
                run = run + 1;
            end
        end
        kept_cnt = KW'(run);
    end

    // Handshakes; in_ready ignores a same-cycle pop so a full batch always fits.
    always_comb begin
        in_ready   = ((DEPTH_L - level_q) >= SAMPLE_L) && !flush;
        out_valid  = (level_q != '0);
        accept     = in_valid && in_ready;
        pop        = out_valid && out_ready;
        push_cnt   = accept ? kept_cnt : '0;
        level_next = level_q + LW'(push_cnt) - LW'(pop);
    end

    // Saturating statistics for the next accept.
    always_comb begin
        drop_inc   = SAMPLE_K - kept_cnt;
        drop_sum   = {1'b0, drop_q} + (CNT_WIDTH + 1)'(drop_inc);
        drop_next  = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
        batch_next = (batch_q == '1) ? batch_q : batch_q + 1'b1;
    end

    // Queue storage: kept lanes land in consecutive slots from the write pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            for (int unsigned i = 0; i < SAMPLE; i++) begin
                if (keep[i]) begin
                    mem[wr_ptr + slot_off[i]] <= in_index[i];
                end
            end
        end
    end

    // Pointers and occupancy; flush empties the queue but leaves counters alone.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(kept_cnt);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level_q <= level_next;
        end
    end

    // Statistics counters, updated only on an accepted batch.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q  <= '0;
            batch_q <= '0;
        end else if (accept) begin
            drop_q  <= drop_next;
            batch_q <= batch_next;
        end
    end

    assign out_index   = out_valid ? mem[rd_ptr] : '0;
    assign level       = level_q;
    assign drop_count  = drop_q;
    assign batch_count = batch_q;

endmodule

// File: tb/tb_spin_index_dispatcher.sv
// Scoreboard bench for spin_index_dispatcher: the driver pushes hand-computed
// surviving indices on each accept; a monitor pops and compares on every pop.
module tb_spin_index_dispatcher;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_index [4];
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_index;
    logic [4:0]  level;
    logic [3:0]  drop_count;
    logic [3:0]  batch_count;

    int total = 0;
    int bad   = 0;
    int unsigned exp_q[$];

    spin_index_dispatcher #(
        .SAMPLE(4),
        .ADDR_BITWIDTH(10),
        .NUM_SPINS(1000),
        .FIFO_DEPTH(16),
        .CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_index(in_index),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_index(out_index),
        .level(level),
        .drop_count(drop_count),
        .batch_count(batch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every pop must match the head of the expected queue.
    always @(negedge clk) begin
        int unsigned e;
        #2;
        if (!reset && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected got=%0d expected=none", out_index);
            end else begin
                e = exp_q.pop_front();
                chk("pop_index", out_index, e);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_idx(input int unsigned a0, input int unsigned a1,
                           input int unsigned a2, input int unsigned a3);
        in_index[0] = 10'(a0);
        in_index[1] = 10'(a1);
        in_index[2] = 10'(a2);
        in_index[3] = 10'(a3);
    endtask

    // Present a batch, wait (bounded) for in_ready, record expected survivors.
    task automatic send(input int unsigned a0, input int unsigned a1,
                        input int unsigned a2, input int unsigned a3,
                        input int n,
                        input int unsigned e0, input int unsigned e1,
                        input int unsigned e2, input int unsigned e3);
        int unsigned ev [4];
        int waited;
        ev = '{e0, e1, e2, e3};
        in_valid = 1'b1;
        set_idx(a0, a1, a2, a3);
        #1;
        waited = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout got=in_ready_low expected=in_ready_high");
            in_valid = 1'b0;
            return;
        end
        for (int i = 0; i < n; i++) exp_q.push_back(ev[i]);
        @(posedge clk);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int k;
        k = 0;
        while (out_valid && k < budget) begin
            tick();
            k++;
        end
        chk("drain_done", out_valid, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        set_idx(0, 0, 0, 0);
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset / idle state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_batch", batch_count, 0);

        // Duplicate + out-of-range filtering, one-cycle latency
        out_ready = 1'b1;
        send(5, 9, 5, 1023, 2, 5, 9, 0, 0);
        chk("latency_out_valid", out_valid, 1);
        wait_empty(20);
        chk("filt_drop", drop_count, 2);
        chk("filt_batch", batch_count, 1);
        chk("filt_level", level, 0);

        // Fill to full with out_ready low
        do_reset();
        out_ready = 1'b0;
        send(0, 1, 2, 3, 4, 0, 1, 2, 3);
        send(4, 5, 6, 7, 4, 4, 5, 6, 7);
        send(8, 9, 10, 11, 4, 8, 9, 10, 11);
        chk("fill_level12", level, 12);
        chk("fill_ready12", in_ready, 1);
        send(12, 13, 14, 15, 4, 12, 13, 14, 15);
        chk("full_level", level, 16);
        chk("full_ready", in_ready, 0);
        in_valid = 1'b1;
        set_idx(20, 21, 22, 23);
        tick();
        chk("held_level", level, 16);
        chk("held_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("lvl13_level", level, 13);
        chk("lvl13_ready", in_ready, 0);
        // Accept with simultaneous pop: 12 + 4 - 1
        send(20, 21, 22, 23, 4, 20, 21, 22, 23);
        chk("push_pop_level", level, 15);
        wait_empty(40);
        chk("fill_batch", batch_count, 5);
        chk("fill_drop", drop_count, 0);

        // Flush with a batch presented
        do_reset();
        out_ready = 1'b0;
        send(999, 1000, 999, 3, 2, 999, 3, 0, 0);
        chk("edge_level", level, 2);
        chk("edge_head", out_index, 999);
        send(7, 7, 7, 7, 1, 7, 0, 0, 0);
        chk("pre_flush_level", level, 3);
        flush = 1'b1;
        in_valid = 1'b1;
        set_idx(40, 41, 42, 43);
        #1;
        chk("flush_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        chk("flush_level", level, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_index", out_index, 0);
        chk("flush_drop", drop_count, 5);
        chk("flush_batch", batch_count, 2);
        out_ready = 1'b1;
        send(50, 51, 52, 53, 4, 50, 51, 52, 53);
        wait_empty(20);

        // Counter saturation with all-dropped batches, then reset mid-stream
        do_reset();
        out_ready = 1'b0;
        repeat (3) send(1023, 1000, 1020, 1001, 0, 0, 0, 0, 0);
        chk("sat3_drop", drop_count, 12);
        chk("sat3_batch", batch_count, 3);
        repeat (14) send(1023, 1000, 1020, 1001, 0, 0, 0, 0, 0);
        chk("sat_batch", batch_count, 15);
        chk("sat_drop", drop_count, 15);
        chk("sat_level", level, 0);
        chk("sat_out_valid", out_valid, 0);
        send(1, 2, 3, 4, 4, 1, 2, 3, 4);
        send(5, 5, 6, 1000, 2, 5, 6, 0, 0);
        chk("mid_level", level, 6);
        chk("mid_batch", batch_count, 15);
        reset = 1'b1;
        tick();
        exp_q.delete();
        chk("mid_rst_level", level, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_index", out_index, 0);
        chk("mid_rst_drop", drop_count, 0);
        chk("mid_rst_batch", batch_count, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_out_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
